pixel_scheduler: RTL and testbench
==================================

// Module: pixel_scheduler
// PURPOSE
//  Upstream feeder of the ray-tracing renderer. Issues (hcount, vcount) pixel coordinates in raster order over one frame.
//  Drives them on paired AXI-Stream-style channels, together with a per-frame select_objs code.
//  Bounds the number of pixels in flight inside the renderer's 339-cycle pipeline with a credit counter.
//  Reports frame completion once every issued pixel has retired downstream.
// PARAMETERS
//  H_PIXELS      320  pixels per line; hcount range 0..H_PIXELS-1 (<= 2048)
//  V_PIXELS      180  lines per frame; vcount range 0..V_PIXELS-1 (<= 1024)
//  MAX_INFLIGHT  512  max issued-but-not-retired pixels (>= 1)
// PORTS
//  aclk                clock  input   1   clock; all logic on rising edge
//  areset              input   1   asynchronous reset, active-high
//  start               input   1   1-cycle pulse: begin a frame (honoured only in IDLE)
//  select_objs_cfg     input   2   object-select code, latched on accepted start
//  hcount_axis_tdata   output  11  pixel column
//  hcount_axis_tvalid  output  1   coordinate valid
//  hcount_axis_tready  input   1   renderer ready (h channel)
//  vcount_axis_tdata   output  10  pixel row
//  vcount_axis_tvalid  output  1   identical to hcount_axis_tvalid
//  vcount_axis_tready  input   1   renderer ready (v channel)
//  select_objs         output  2   latched code, held constant for the whole frame
//  pixel_retire        input   1   1-cycle pulse per pixel leaving renderer (pixel tvalid & tready)
//  busy                output  1   high outside IDLE
//  frame_done          output  1   1-cycle pulse when frame fully retired
//  credit_err          output  1   sticky: retire seen with zero pixels in flight
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; tvalid=0, tdata=0, select_objs=0, busy=0, frame_done=0, credit_err=0, in_flight=0.
//  Beat accepted (fire) when tvalid & hcount_axis_tready & vcount_axis_tready.
//   Both channels always transfer together.
//  AXI rule: once tvalid=1, tdata is held stable until fire; tvalid never drops without fire (except reset).
//  FSM:
//   IDLE : start=1 -> ISSUE.
//    Latch select_objs_cfg; h=0, v=0; tvalid=1 from the next cycle (latency 1).
//   ISSUE: tvalid = (in_flight < MAX_INFLIGHT) or a beat already presented.
//    Credits gate only the raising of tvalid, never an already-presented beat.
//    On fire: h++; when h==H_PIXELS-1, h=0 and v++.
//    Fire of (H_PIXELS-1, V_PIXELS-1) -> DRAIN, tvalid=0 the next cycle.
//   DRAIN: tvalid=0. When in_flight==0 (including the same cycle as the last retire): frame_done=1 for one cycle -> IDLE.
//  Throughput 1 pixel/cycle while ready and credits are available.
//   Back-to-back fires present the next coordinate with no bubble.
//  in_flight: +1 on fire, -1 on pixel_retire. Both in the same cycle -> unchanged.
//   Retire with in_flight==0 -> ignored, credit_err set (cleared only by reset).
//   in_flight never exceeds MAX_INFLIGHT.
//  start outside IDLE is ignored, including in the frame_done cycle.
//   start in the cycle after frame_done begins a new frame.
//  Counter widths: h 11b, v 10b, in_flight $clog2(MAX_INFLIGHT+1) bits. No wrap beyond frame bounds.
//  Reset mid-frame aborts immediately: all state returns to reset values; no frame_done.
//  Degenerate 1x1 frame: single beat (0,0), then DRAIN.
// STRUCTURE
//  render_pkg (shared): HCOUNT_W=11, VCOUNT_W=10, SEL_SPHERE=2'b01, SEL_CYL=2'b10, SEL_BOTH=2'b11, sched_state_t {IDLE, ISSUE, DRAIN}.
//  Sub-module credit_counter #(MAX) (inc, dec, count, full, empty, err): the only natural split.
//   Raster counters and FSM stay in this module.
// TESTING
//  1. H=4,V=2, readies held 1, start, retire each pixel 339 cycles after issue.
//   -> 8 fires on consecutive cycles (0,0)..(3,0),(0,1)..(3,1).
//   -> frame_done exactly once, 339 cycles after the last fire.
//  2. Readies low 5 cycles while beat (2,0) is presented.
//   -> tvalid stays 1 and data holds (2,0) until fire; no skipped or duplicated coordinate.
//  3. MAX_INFLIGHT=3, no retires.
//   -> 3 fires, then tvalid=0. One retire -> exactly one more fire.
//   -> Simultaneous fire+retire leaves in_flight unchanged.
//  4. select_objs_cfg=2'b10 at start, changed to 2'b01 mid-frame.
//   -> select_objs=2'b10 for the whole frame.
//   -> A second start during ISSUE is ignored (no coordinate restart).
//  5. areset pulsed mid-ISSUE at (1,1).
//   -> tvalid=0, busy=0 immediately. Next start begins at (0,0). No frame_done.
//  6. pixel_retire pulsed in IDLE -> credit_err=1 and stays 1; in_flight stays 0.

Source files
------------

// File: rtl/render_pkg.sv
// Shared renderer definitions: coordinate widths, object-select codes and the scheduler state type.
package render_pkg;
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  localparam logic [1:0] SEL_SPHERE = 2'b01;
  localparam logic [1:0] SEL_CYL    = 2'b10;
  localparam logic [1:0] SEL_BOTH   = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} sched_state_t;
endpackage

// File: rtl/pixel_scheduler_if.sv
// Paired hcount/vcount AXI-Stream-style coordinate channels between scheduler and renderer.
interface pixel_scheduler_if;
  import render_pkg::*;

  logic [HCOUNT_W-1:0] hcount_axis_tdata;
  logic                hcount_axis_tvalid;
  logic                hcount_axis_tready;
  logic [VCOUNT_W-1:0] vcount_axis_tdata;
  logic                vcount_axis_tvalid;
  logic                vcount_axis_tready;

  modport master (
    output hcount_axis_tdata, hcount_axis_tvalid,
    input  hcount_axis_tready,
    output vcount_axis_tdata, vcount_axis_tvalid,
    input  vcount_axis_tready
  );

  modport slave (
    input  hcount_axis_tdata, hcount_axis_tvalid,
    output hcount_axis_tready,
    input  vcount_axis_tdata, vcount_axis_tvalid,
    output vcount_axis_tready
  );
endinterface

// File: rtl/pixel_scheduler_credit_counter.sv
// Counts issued-but-not-retired pixels; flags a sticky error on retire with nothing in flight.
module credit_counter #(
  parameter  int unsigned MAX = 512,
  localparam int unsigned CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          take;

  assign take = dec && (count_q != '0);

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (dec && (count_q == '0)) err_d = 1'b1;
    unique case ({inc, take})
      2'b10:   if (count_q != CW'(MAX)) count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  // full looks one cycle ahead so tvalid can be raised back-to-back without overshooting
  assign full  = (count_d == CW'(MAX));
  assign empty = (count_q == '0);
  assign err   = err_q;
endmodule

// File: rtl/pixel_scheduler.sv
// Raster-order pixel coordinate issuer for the ray-tracing renderer, credit-limited,
// reporting frame completion once every issued pixel has retired.
module pixel_scheduler
  import render_pkg::*;
#(
  parameter int unsigned H_PIXELS     = 320,
  parameter int unsigned V_PIXELS     = 180,
  parameter int unsigned MAX_INFLIGHT = 512
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [1:0]        select_objs_cfg,
  pixel_scheduler_if.master axis,
  output logic [1:0]        select_objs,
  input  logic              pixel_retire,
  output logic              busy,
  output logic              frame_done,
  output logic              credit_err
);
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_PIXELS - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_PIXELS - 1);

  sched_state_t        state_q, state_d;
  logic [HCOUNT_W-1:0] h_q, h_d;
  logic [VCOUNT_W-1:0] v_q, v_d;
  logic                valid_q, valid_d;
  logic [1:0]          sel_q, sel_d;

  logic          fire, last_beat, drained;
  logic [CW-1:0] in_flight;
  logic          cc_full, cc_empty;

  assign fire      = valid_q & axis.hcount_axis_tready & axis.vcount_axis_tready;
  assign last_beat = (h_q == H_LAST) && (v_q == V_LAST);
  // Completes in the same cycle as the final retire, not one cycle later
  assign drained   = cc_empty || ((in_flight == CW'(1)) && pixel_retire);

  credit_counter #(.MAX(MAX_INFLIGHT)) u_credit (
    .clk   (aclk),
    .rst   (areset),
    .inc   (fire),
    .dec   (pixel_retire),
    .count (in_flight),
    .full  (cc_full),
    .empty (cc_empty),
    .err   (credit_err)
  );

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    v_d        = v_q;
    valid_d    = valid_q;
    sel_d      = sel_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          h_d     = '0;
          v_d     = '0;
          sel_d   = select_objs_cfg;
          valid_d = 1'b1;
        end
      end
      ISSUE: begin
        if (fire) begin
          if (last_beat) begin
            state_d = DRAIN;
            valid_d = 1'b0;
          end else begin
            if (h_q == H_LAST) begin
              h_d = '0;
              v_d = v_q + 1'b1;
            end else begin
              h_d = h_q + 1'b1;
            end
            valid_d = !cc_full;
          end
        end else if (!valid_q) begin
          valid_d = !cc_full;
        end
      end
      DRAIN: begin
        valid_d = 1'b0;
        if (drained) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign axis.hcount_axis_tdata  = h_q;
  assign axis.hcount_axis_tvalid = valid_q;
  assign axis.vcount_axis_tdata  = v_q;
  assign axis.vcount_axis_tvalid = valid_q;
  assign select_objs             = sel_q;
  assign busy                    = (state_q != IDLE);
endmodule

// File: tb/tb_pixel_scheduler.sv
// Randomized self-checking bench for pixel_scheduler against a raster/credit reference model.
module tb_pixel_scheduler;
  localparam int H   = 4;
  localparam int V   = 2;
  localparam int LAT = 339;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  always #5 aclk = ~aclk;

  logic       start_a = 1'b0, retire_a = 1'b0;
  logic [1:0] cfg_a = 2'b00, sel_a;
  logic       busy_a, done_a, err_a;
  logic       start_b = 1'b0, retire_b = 1'b0;
  logic [1:0] cfg_b = 2'b00, sel_b;
  logic       busy_b, done_b, err_b;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_scheduler_if if_a ();
  pixel_scheduler_if if_b ();

  pixel_scheduler #(.H_PIXELS(H), .V_PIXELS(V)) dut_a (
    .aclk(aclk), .areset(areset), .start(start_a), .select_objs_cfg(cfg_a), .axis(if_a),
    .select_objs(sel_a), .pixel_retire(retire_a), .busy(busy_a), .frame_done(done_a),
    .credit_err(err_a)
  );

  pixel_scheduler #(.H_PIXELS(H), .V_PIXELS(V), .MAX_INFLIGHT(3)) dut_b (
    .aclk(aclk), .areset(areset), .start(start_b), .select_objs_cfg(cfg_b), .axis(if_b),
    .select_objs(sel_b), .pixel_retire(retire_b), .busy(busy_b), .frame_done(done_b),
    .credit_err(err_b)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1; start_a = 1'b0; start_b = 1'b0; retire_a = 1'b0; retire_b = 1'b0;
    step();
    step();
    n_tests++;
    if (if_a.hcount_axis_tvalid !== 1'b0 || if_a.vcount_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_a: got %b/%b want 0/0", if_a.hcount_axis_tvalid, if_a.vcount_axis_tvalid);
    end
    n_tests++;
    if (if_a.hcount_axis_tdata !== 11'd0 || if_a.vcount_axis_tdata !== 10'd0) begin
      n_fail++; $display("FAIL reset_data_a: got (%0d,%0d) want (0,0)", if_a.hcount_axis_tdata, if_a.vcount_axis_tdata);
    end
    n_tests++;
    if (sel_a !== 2'b00 || busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_status_a: got sel=%b busy=%b done=%b err=%b want 0,0,0,0", sel_a, busy_a, done_a, err_a);
    end
    n_tests++;
    if (dut_a.in_flight !== 10'd0) begin
      n_fail++; $display("FAIL reset_inflight_a: got %0d want 0", dut_a.in_flight);
    end
    n_tests++;
    if (if_b.hcount_axis_tvalid !== 1'b0 || busy_b !== 1'b0 || err_b !== 1'b0 || done_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_status_b: got valid=%b busy=%b err=%b done=%b want 0", if_b.hcount_axis_tvalid, busy_b, err_b, done_b);
    end
    areset = 1'b0;
    step();
  endtask

  // One frame on dut_a; sel_in < 0 picks a random select code.
  task automatic run_frame_a(input int rdy_pct, input int lat_min, input int lat_max,
                             input bit stall_20, input bit cfg_poke, input int sel_in);
    int q_h[$];
    int q_v[$];
    int due[$];
    int infl, cyc, last_fire, last_due, dones, stall, done_cyc, lat, k, prev_h, prev_v;
    bit prev_valid, prev_fire, fin, fire, exp_done, rdy, hr, vr;
    logic [1:0] sel_exp;
    infl = 0; cyc = 0; last_fire = -1; last_due = -1; dones = 0; stall = 0; done_cyc = -1;
    prev_h = 0; prev_v = 0; prev_valid = 1'b0; prev_fire = 1'b0; fin = 1'b0;
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) begin
        q_h.push_back(h);
        q_v.push_back(v);
      end
    sel_exp = (sel_in < 0) ? 2'($urandom_range(3)) : 2'(sel_in);
    cfg_a = sel_exp;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    while (!fin && cyc < 2000) begin
      retire_a = (due.size() > 0 && due[0] == cyc);
      if (stall_20 && if_a.hcount_axis_tvalid === 1'b1 && if_a.hcount_axis_tdata == 11'd2 &&
          if_a.vcount_axis_tdata == 10'd0 && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end else begin
        rdy = ($urandom_range(99) < rdy_pct);
      end
      if (rdy) begin
        hr = 1'b1; vr = 1'b1;
      end else begin
        k = $urandom_range(2);
        hr = (k == 1); vr = (k == 2);
      end
      if_a.hcount_axis_tready = hr;
      if_a.vcount_axis_tready = vr;
      if (cfg_poke) begin
        cfg_a = ~sel_exp;
        start_a = (cyc == 3);
      end
      #1;
      if (cyc == 0) begin
        n_tests++;
        if (if_a.hcount_axis_tvalid !== 1'b1) begin
          n_fail++; $display("FAIL start_latency: got tvalid=%b want 1", if_a.hcount_axis_tvalid);
        end
      end
      n_tests++;
      if (busy_a !== 1'b1) begin
        n_fail++; $display("FAIL busy_frame: cycle %0d got %b want 1", cyc, busy_a);
      end
      n_tests++;
      if (sel_a !== sel_exp) begin
        n_fail++; $display("FAIL select_hold: cycle %0d got %b want %b", cyc, sel_a, sel_exp);
      end
      if (prev_valid && !prev_fire) begin
        n_tests++;
        if (if_a.hcount_axis_tvalid !== 1'b1 || if_a.hcount_axis_tdata !== 11'(prev_h) ||
            if_a.vcount_axis_tdata !== 10'(prev_v)) begin
          n_fail++; $display("FAIL axis_hold: cycle %0d got v=%b (%0d,%0d) want 1 (%0d,%0d)", cyc,
                             if_a.hcount_axis_tvalid, if_a.hcount_axis_tdata, if_a.vcount_axis_tdata, prev_h, prev_v);
        end
      end
      if (if_a.hcount_axis_tvalid === 1'b1) begin
        n_tests++;
        if (q_h.size() == 0) begin
          n_fail++; $display("FAIL extra_beat: cycle %0d got (%0d,%0d) want none", cyc,
                             if_a.hcount_axis_tdata, if_a.vcount_axis_tdata);
        end else if (if_a.hcount_axis_tdata !== 11'(q_h[0]) || if_a.vcount_axis_tdata !== 10'(q_v[0])) begin
          n_fail++; $display("FAIL coord: cycle %0d got (%0d,%0d) want (%0d,%0d)", cyc,
                             if_a.hcount_axis_tdata, if_a.vcount_axis_tdata, q_h[0], q_v[0]);
        end
      end
      n_tests++;
      if (if_a.vcount_axis_tvalid !== if_a.hcount_axis_tvalid) begin
        n_fail++; $display("FAIL valid_pair: got v=%b h=%b want equal", if_a.vcount_axis_tvalid, if_a.hcount_axis_tvalid);
      end
      exp_done = (q_h.size() == 0) && (cyc > last_fire) && (infl - int'(retire_a) == 0);
      n_tests++;
      if (done_a !== exp_done) begin
        n_fail++; $display("FAIL frame_done: cycle %0d got %b want %b", cyc, done_a, exp_done);
      end
      fire = (if_a.hcount_axis_tvalid === 1'b1) && hr && vr;
      if (fire) begin
        if (rdy_pct == 100 && !stall_20 && last_fire >= 0) begin
          n_tests++;
          if (cyc != last_fire + 1) begin
            n_fail++; $display("FAIL back_to_back: got fire at %0d want %0d", cyc, last_fire + 1);
          end
        end
        if (q_h.size() > 0) begin
          void'(q_h.pop_front());
          void'(q_v.pop_front());
        end
        infl++;
        lat = $urandom_range(lat_max, lat_min);
        last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        due.push_back(last_due);
        last_fire = cyc;
      end
      if (retire_a) begin
        void'(due.pop_front());
        infl--;
      end
      if (done_a === 1'b1) begin
        dones++;
        done_cyc = cyc;
        fin = 1'b1;
      end
      prev_valid = (if_a.hcount_axis_tvalid === 1'b1);
      prev_fire  = fire;
      prev_h     = int'(if_a.hcount_axis_tdata);
      prev_v     = int'(if_a.vcount_axis_tdata);
      cyc++;
      step();
    end
    retire_a = 1'b0;
    start_a = 1'b0;
    n_tests++;
    if (dones != 1 || q_h.size() != 0) begin
      n_fail++; $display("FAIL frame_end: got done=%0d left=%0d want done=1 left=0", dones, q_h.size());
    end
    if (lat_min == LAT && lat_max == LAT) begin
      n_tests++;
      if (done_cyc - last_fire != LAT) begin
        n_fail++; $display("FAIL done_latency: got %0d want %0d", done_cyc - last_fire, LAT);
      end
    end
    if (stall_20) begin
      n_tests++;
      if (stall != 5) begin
        n_fail++; $display("FAIL stall_seen: got %0d want 5", stall);
      end
    end
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++; $display("FAIL busy_after: got %b want 0", busy_a);
    end
  endtask

  task automatic test_single_frame();
    run_frame_a(100, LAT, LAT, 1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_frame_a(100, 1, 8, 1'b1, 1'b0, -1);
  endtask

  task automatic test_select_hold();
    run_frame_a(100, 2, 6, 1'b0, 1'b1, 2);
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 3; i++) run_frame_a(60, 1, 25, 1'b0, 1'b0, -1);
  endtask

  task automatic test_credit_limit();
    int fires;
    bit got;
    fires = 0;
    got = 1'b0;
    if_b.hcount_axis_tready = 1'b1;
    if_b.vcount_axis_tready = 1'b1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (if_b.hcount_axis_tvalid === 1'b1) begin
        n_tests++;
        if (if_b.hcount_axis_tdata !== 11'(fires % H) || if_b.vcount_axis_tdata !== 10'(fires / H)) begin
          n_fail++; $display("FAIL credit_coord: got (%0d,%0d) want (%0d,%0d)", if_b.hcount_axis_tdata,
                             if_b.vcount_axis_tdata, fires % H, fires / H);
        end
        fires++;
      end
      step();
    end
    n_tests++;
    if (fires != 3 || if_b.hcount_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL credit_stop: got fires=%0d valid=%b want 3,0", fires, if_b.hcount_axis_tvalid);
    end
    retire_b = 1'b1;
    step();
    retire_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (if_b.hcount_axis_tvalid === 1'b1) fires++;
      step();
    end
    n_tests++;
    if (fires != 4) begin
      n_fail++; $display("FAIL credit_one_more: got fires=%0d want 4", fires);
    end
    n_tests++;
    if (dut_b.in_flight !== 2'd3) begin
      n_fail++; $display("FAIL credit_count_full: got %0d want 3", dut_b.in_flight);
    end
    if_b.hcount_axis_tready = 1'b0;
    if_b.vcount_axis_tready = 1'b0;
    retire_b = 1'b1;
    step();
    retire_b = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (if_b.hcount_axis_tvalid === 1'b1) got = 1'b1;
      else step();
    end
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL credit_reraise: got tvalid=0 want 1 within 10 cycles");
    end
    n_tests++;
    if (dut_b.in_flight !== 2'd2) begin
      n_fail++; $display("FAIL credit_count_pre: got %0d want 2", dut_b.in_flight);
    end
    if_b.hcount_axis_tready = 1'b1;
    if_b.vcount_axis_tready = 1'b1;
    retire_b = 1'b1;
    step();
    if_b.hcount_axis_tready = 1'b0;
    if_b.vcount_axis_tready = 1'b0;
    retire_b = 1'b0;
    n_tests++;
    if (dut_b.in_flight !== 2'd2) begin
      n_fail++; $display("FAIL credit_fire_retire: got %0d want 2", dut_b.in_flight);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit hit;
    hit = 1'b0;
    if_a.hcount_axis_tready = 1'b1;
    if_a.vcount_axis_tready = 1'b1;
    cfg_a = 2'b11;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (if_a.hcount_axis_tvalid === 1'b1 && if_a.hcount_axis_tdata == 11'd1 && if_a.vcount_axis_tdata == 10'd1) begin
        areset = 1'b1;
        #1;
        hit = 1'b1;
        n_tests++;
        if (if_a.hcount_axis_tvalid !== 1'b0 || if_a.vcount_axis_tvalid !== 1'b0 || busy_a !== 1'b0) begin
          n_fail++; $display("FAIL abort_outputs: got valid=%b busy=%b want 0,0", if_a.hcount_axis_tvalid, busy_a);
        end
        n_tests++;
        if (if_a.hcount_axis_tdata !== 11'd0 || if_a.vcount_axis_tdata !== 10'd0 || sel_a !== 2'b00) begin
          n_fail++; $display("FAIL abort_state: got (%0d,%0d) sel=%b want (0,0) 00", if_a.hcount_axis_tdata,
                             if_a.vcount_axis_tdata, sel_a);
        end
      end else begin
        step();
      end
    end
    n_tests++;
    if (!hit) begin
      n_fail++; $display("FAIL abort_reach: got no (1,1) beat want one");
    end
    step();
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        n_fail++; $display("FAIL abort_quiet: got done=%b busy=%b want 0,0", done_a, busy_a);
      end
      step();
    end
    run_frame_a(100, 1, 5, 1'b0, 1'b0, -1);
  endtask

  task automatic test_credit_err();
    retire_a = 1'b1;
    step();
    retire_a = 1'b0;
    n_tests++;
    if (err_a !== 1'b1) begin
      n_fail++; $display("FAIL credit_err_set: got %b want 1", err_a);
    end
    n_tests++;
    if (dut_a.in_flight !== 10'd0) begin
      n_fail++; $display("FAIL credit_err_count: got %0d want 0", dut_a.in_flight);
    end
    repeat (5) step();
    n_tests++;
    if (err_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL credit_err_sticky: got err=%b busy=%b want 1,0", err_a, busy_a);
    end
    areset = 1'b1;
    step();
    areset = 1'b0;
    n_tests++;
    if (err_a !== 1'b0) begin
      n_fail++; $display("FAIL credit_err_clear: got %b want 0", err_a);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.hcount_axis_tready = 1'b0;
    if_a.vcount_axis_tready = 1'b0;
    if_b.hcount_axis_tready = 1'b0;
    if_b.vcount_axis_tready = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_select_hold();
    test_credit_limit();
    test_reset();
    test_reset_mid_frame();
    test_random_frames();
    test_credit_err();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
